// File: rtl/vector_mem_ctrl_pkg.sv
// Shared definitions for the vector memory controller.
// Holds the data-cache command and status codes, the vsew element-size codes,
// the controller state encoding and small decode helpers for element size.
package vector_mem_ctrl_pkg;

  // Commands driven on cache_vis_signal.
  localparam logic [1:0] D_CACHE_NOP   = 2'b00;
  localparam logic [1:0] D_CACHE_LOAD  = 2'b01;
  localparam logic [1:0] D_CACHE_STORE = 2'b10;
  localparam logic [1:0] D_CACHE_REST  = 2'b11;

  // Status codes reported on d_cache_vis_status.
  localparam logic [1:0] D_CACHE_RESTING = 2'b00;
  localparam logic [1:0] D_CACHE_WORKING = 2'b01;
  localparam logic [1:0] D_CACHE_STALL   = 2'b10;
  localparam logic [1:0] L_S_FINISHED    = 2'b11;

  // vsew element-size codes.
  localparam logic [2:0] ONE_BYTE   = 3'b000;
  localparam logic [2:0] TWO_BYTE   = 3'b001;
  localparam logic [2:0] FOUR_BYTE  = 3'b010;
  localparam logic [2:0] EIGHT_BYTE = 3'b011;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } vmc_state_e;

  // Only 1/2/4-byte elements fit a single cache access.
  function automatic logic type_legal(input logic [2:0] t);
    return (t == ONE_BYTE) || (t == TWO_BYTE) || (t == FOUR_BYTE);
  endfunction

  // log2 of the element size in bytes (only meaningful for legal types).
  function automatic logic [1:0] elem_shift(input logic [2:0] t);
    return t[1:0];
  endfunction

endpackage

// File: rtl/vector_mem_ctrl_if.sv
// Bus bundle between the controller, the LSU and the data cache.
// master: environment side (LSU request + cache responses).
// slave : controller side (request acceptance, results, cache commands).
// Signals: req_* request fields and req_ready; result_vdata/done/err results;
// data_addr/data_type/cache_written_data/cache_vis_signal/length cache command;
// data/d_cache_vis_status cache response.
interface vector_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned DATA_LEN         = 32,
  parameter int unsigned VECTOR_SIZE      = 8,
  parameter int unsigned ENTRY_INDEX_SIZE = 3
) ();

  logic                            req_valid;
  logic                            req_ready;
  logic                            req_is_store;
  logic                            req_is_vector;
  logic [ADDR_WIDTH-1:0]           req_addr;
  logic [2:0]                      req_data_type;
  logic [ENTRY_INDEX_SIZE:0]       req_vl;
  logic [VECTOR_SIZE-1:0]          req_mask;
  logic [DATA_LEN*VECTOR_SIZE-1:0] req_vdata;
  logic [DATA_LEN*VECTOR_SIZE-1:0] result_vdata;
  logic                            done;
  logic                            err;
  logic [ADDR_WIDTH-1:0]           data_addr;
  logic [2:0]                      data_type;
  logic [DATA_LEN-1:0]             cache_written_data;
  logic [1:0]                      cache_vis_signal;
  logic [ENTRY_INDEX_SIZE:0]       length;
  logic [DATA_LEN-1:0]             data;
  logic [1:0]                      d_cache_vis_status;

  modport master (
    output req_valid, req_is_store, req_is_vector, req_addr, req_data_type, req_vl, req_mask,
           req_vdata, data, d_cache_vis_status,
    input  req_ready, result_vdata, done, err, data_addr, data_type, cache_written_data,
           cache_vis_signal, length
  );

  modport slave (
    input  req_valid, req_is_store, req_is_vector, req_addr, req_data_type, req_vl, req_mask,
           req_vdata, data, d_cache_vis_status,
    output req_ready, result_vdata, done, err, data_addr, data_type, cache_written_data,
           cache_vis_signal, length
  );

endinterface

// File: rtl/vmc_next_elem.sv
// Priority search for the lowest enabled element index >= start and < vl.
// Ports: start (search origin), vl (element count), mask (per-element enable),
// found (an element exists), idx (its index, 0 when none).
module vmc_next_elem #(
  parameter int unsigned VECTOR_SIZE      = 8,
  parameter int unsigned ENTRY_INDEX_SIZE = 3
) (
  input  logic [ENTRY_INDEX_SIZE:0]   start,
  input  logic [ENTRY_INDEX_SIZE:0]   vl,
  input  logic [VECTOR_SIZE-1:0]      mask,
  output logic                        found,
  output logic [ENTRY_INDEX_SIZE-1:0] idx
);

  typedef logic [ENTRY_INDEX_SIZE:0]   cnt_t;
  typedef logic [ENTRY_INDEX_SIZE-1:0] idx_t;

  // Scan downwards so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = VECTOR_SIZE - 1; i >= 0; i--) begin
      if (mask[i] && (cnt_t'(i) >= start) && (cnt_t'(i) < vl)) begin
        found = 1'b1;
        idx   = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/vector_mem_ctrl.sv
// Vector memory controller: splits one scalar or unit-stride vector load/store
// into single-element data-cache accesses, gathers load data into result_vdata.
// Ports: clk, rst_n (synchronous, active-low), bus (vector_mem_ctrl_if.slave).
// Optional feature: define VECTOR_MEM_CTRL_MASK_EN to skip elements whose
// req_mask bit is 0; otherwise every element below vl is accessed.
module vector_mem_ctrl
  import vector_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 17,
  parameter int unsigned DATA_LEN         = 32,
  parameter int unsigned VECTOR_SIZE      = 8,
  parameter int unsigned ENTRY_INDEX_SIZE = 3
) (
  input logic              clk,
  input logic              rst_n,
  vector_mem_ctrl_if.slave bus
);

  typedef logic [ENTRY_INDEX_SIZE:0]   cnt_t;
  typedef logic [ENTRY_INDEX_SIZE-1:0] idx_t;

  vmc_state_e                      state_q, state_d;
  logic                            is_store_q, is_store_d;
  logic [ADDR_WIDTH-1:0]           base_q, base_d;
  logic [2:0]                      type_q, type_d;
  cnt_t                            vl_q, vl_d;
  logic [VECTOR_SIZE-1:0]          mask_q, mask_d;
  idx_t                            idx_q, idx_d;
  logic [DATA_LEN*VECTOR_SIZE-1:0] result_q, result_d;
  logic                            err_q, err_d;
  logic [1:0]                      vis_q, vis_d;
  logic [ADDR_WIDTH-1:0]           daddr_q, daddr_d;
  logic [2:0]                      dtype_q, dtype_d;
  logic [DATA_LEN-1:0]             wdata_q, wdata_d;

  cnt_t                   req_vl_eff;
  logic [VECTOR_SIZE-1:0] req_mask_eff;
  cnt_t                   ne_start, ne_vl;
  logic [VECTOR_SIZE-1:0] ne_mask;
  logic                   ne_found;
  idx_t                   ne_idx;

  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input idx_t i, input logic [2:0] t);
    return base + (ADDR_WIDTH'(i) << elem_shift(t));
  endfunction

  // Scalars behave as vl=1 with only lane 0 enabled.
  always_comb begin
    if (!bus.req_is_vector) begin
      req_vl_eff = cnt_t'(1);
    end else if (bus.req_vl > cnt_t'(VECTOR_SIZE)) begin
      req_vl_eff = cnt_t'(VECTOR_SIZE);
    end else begin
      req_vl_eff = bus.req_vl;
    end
  end

`ifdef VECTOR_MEM_CTRL_MASK_EN
  assign req_mask_eff = bus.req_is_vector ? bus.req_mask : VECTOR_SIZE'(1);
`else
  logic unused_mask;
  assign unused_mask  = ^bus.req_mask;
  assign req_mask_eff = '1;
`endif

  // In IDLE the search runs on the incoming request from element 0;
  // afterwards it continues from the element just completed.
  assign ne_start = (state_q == StIdle) ? '0 : cnt_t'(idx_q) + cnt_t'(1);
  assign ne_vl    = (state_q == StIdle) ? req_vl_eff : vl_q;
  assign ne_mask  = (state_q == StIdle) ? req_mask_eff : mask_q;

  vmc_next_elem #(
    .VECTOR_SIZE     (VECTOR_SIZE),
    .ENTRY_INDEX_SIZE(ENTRY_INDEX_SIZE)
  ) u_next_elem (
    .start(ne_start),
    .vl   (ne_vl),
    .mask (ne_mask),
    .found(ne_found),
    .idx  (ne_idx)
  );

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    base_d     = base_q;
    type_d     = type_q;
    vl_d       = vl_q;
    mask_d     = mask_q;
    idx_d      = idx_q;
    result_d   = result_q;
    err_d      = err_q;
    vis_d      = vis_q;
    daddr_d    = daddr_q;
    dtype_d    = dtype_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      StIdle: begin
        vis_d = D_CACHE_NOP;
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          base_d     = bus.req_addr;
          type_d     = bus.req_data_type;
          vl_d       = req_vl_eff;
          mask_d     = req_mask_eff;
          idx_d      = ne_idx;
          result_d   = bus.req_vdata;
          err_d      = !type_legal(bus.req_data_type);
          if (!type_legal(bus.req_data_type) || !ne_found) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            vis_d   = bus.req_is_store ? D_CACHE_STORE : D_CACHE_LOAD;
            daddr_d = elem_addr(bus.req_addr, ne_idx, bus.req_data_type);
            dtype_d = bus.req_data_type;
            wdata_d = bus.req_vdata[ne_idx*DATA_LEN +: DATA_LEN];
          end
        end
      end
      StIssue: begin
        if (bus.d_cache_vis_status == D_CACHE_RESTING) begin
          state_d = StWait;
          vis_d   = D_CACHE_NOP;
        end
      end
      StWait: begin
        if (bus.d_cache_vis_status == L_S_FINISHED) begin
          if (!is_store_q) begin
            result_d[idx_q*DATA_LEN +: DATA_LEN] = bus.data;
          end
          if (ne_found) begin
            state_d = StIssue;
            idx_d   = ne_idx;
            vis_d   = is_store_q ? D_CACHE_STORE : D_CACHE_LOAD;
            daddr_d = elem_addr(base_q, ne_idx, type_q);
            // For stores result_q still equals the source vector.
            wdata_d = result_q[ne_idx*DATA_LEN +: DATA_LEN];
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      base_q     <= '0;
      type_q     <= '0;
      vl_q       <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      vis_q      <= D_CACHE_NOP;
      daddr_q    <= '0;
      dtype_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      base_q     <= base_d;
      type_q     <= type_d;
      vl_q       <= vl_d;
      mask_q     <= mask_d;
      idx_q      <= idx_d;
      result_q   <= result_d;
      err_q      <= err_d;
      vis_q      <= vis_d;
      daddr_q    <= daddr_d;
      dtype_q    <= dtype_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.req_ready          = (state_q == StIdle);
  assign bus.done               = (state_q == StDone);
  assign bus.err                = err_q;
  assign bus.result_vdata       = result_q;
  assign bus.cache_vis_signal   = vis_q;
  assign bus.data_addr          = daddr_q;
  assign bus.data_type          = dtype_q;
  assign bus.cache_written_data = wdata_q;
  assign bus.length             = cnt_t'(1);

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// Directed testbench for vector_mem_ctrl with a simple data-cache model.
module tb_vector_mem_ctrl;
  import vector_mem_ctrl_pkg::*;

  localparam int unsigned AW = 17;
  localparam int unsigned DL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_mem_ctrl_if bus ();

  vector_mem_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;

  // Cache model: accepts a command while resting, stalls stall_cycles, then finishes.
  logic          force_working = 1'b0;
  int            stall_cycles = 0;
  logic [31:0]   load_base = 32'h0;
  logic          m_busy = 1'b0;
  int            m_cnt = 0;
  logic [AW-1:0] m_addr = '0;
  logic [2:0]    m_type = '0;
  logic [AW-1:0] log_addr[64];
  logic [DL-1:0] log_wdata[64];
  logic [1:0]    log_vis[64];
  int            log_n = 0;
  logic [31:0]   m_word;

  always @(posedge clk) begin
    if (!m_busy) begin
      if (!force_working && bus.cache_vis_signal != D_CACHE_NOP) begin
        m_busy           <= 1'b1;
        m_cnt            <= stall_cycles;
        m_addr           <= bus.data_addr;
        m_type           <= bus.data_type;
        log_addr[log_n]  <= bus.data_addr;
        log_wdata[log_n] <= bus.cache_written_data;
        log_vis[log_n]   <= bus.cache_vis_signal;
        log_n            <= log_n + 1;
      end
    end else if (m_cnt == 0) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign m_word = load_base ^ {15'b0, m_addr};
  assign bus.data = (m_type == ONE_BYTE) ? (m_word & 32'hFF) :
                    (m_type == TWO_BYTE) ? (m_word & 32'hFFFF) : m_word;
  assign bus.d_cache_vis_status = force_working ? D_CACHE_WORKING :
                                  !m_busy       ? D_CACHE_RESTING :
                                  (m_cnt == 0)  ? L_S_FINISHED : D_CACHE_STALL;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge after acceptance.
  task automatic send(input logic st, input logic vec, input logic [AW-1:0] a,
                      input logic [2:0] t, input logic [3:0] vl, input logic [7:0] m,
                      input logic [255:0] vd);
    @(negedge clk);
    bus.req_is_store  = st;
    bus.req_is_vector = vec;
    bus.req_addr      = a;
    bus.req_data_type = t;
    bus.req_vl        = vl;
    bus.req_mask      = m;
    bus.req_vdata     = vd;
    bus.req_valid     = 1'b1;
    @(negedge clk);
    bus.req_valid     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.done, 1'b1);
  endtask

  logic [255:0] vd;
  logic [255:0] exp_v;
  logic [7:0]   exp_mask;
  int           base_n;
  int           k;
  logic [AW-1:0] st_addr[8] = '{17'h1FFFC, 17'h1FFFE, 17'h00000, 17'h00002,
                                17'h00004, 17'h00006, 17'h00008, 17'h0000A};
  logic [AW-1:0] ld_addr[4] = '{17'h203, 17'h204, 17'h205, 17'h206};
  logic [31:0]   ld_data[4] = '{32'h12, 32'h15, 32'h14, 32'h17};

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_is_store  = 1'b0;
    bus.req_is_vector = 1'b0;
    bus.req_addr      = '0;
    bus.req_data_type = '0;
    bus.req_vl        = '0;
    bus.req_mask      = '0;
    bus.req_vdata     = '0;
    for (int i = 0; i < 8; i++) vd[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_vis", bus.cache_vis_signal, D_CACHE_NOP);
    check("rst_addr", bus.data_addr, 0);
    check("rst_type", bus.data_type, 0);
    check("rst_wdata", bus.cache_written_data, 0);
    check("rst_result", bus.result_vdata, 0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_length", bus.length, 1);
    rst_n = 1'b1;

    // Scalar FOUR_BYTE load hit; vl and mask must be ignored for scalars
    load_base = 32'hDEADBFEB;
    stall_cycles = 0;
    base_n = log_n;
    send(1'b0, 1'b0, 17'h00104, FOUR_BYTE, 4'd5, 8'h00, vd);
    check("sc_vis", bus.cache_vis_signal, D_CACHE_LOAD);
    check("sc_addr", bus.data_addr, 17'h00104);
    check("sc_type", bus.data_type, FOUR_BYTE);
    check("sc_ready", bus.req_ready, 1'b0);
    wait_done("sc_done", 20);
    check("sc_lane0", bus.result_vdata[31:0], 32'hDEADBEEF);
    check("sc_upper", bus.result_vdata[255:32], vd[255:32]);
    check("sc_err", bus.err, 1'b0);
    check("sc_count", log_n - base_n, 1);
    @(negedge clk);

    // ONE_BYTE vector load with stalls
    load_base = 32'h11;
    stall_cycles = 3;
    base_n = log_n;
    send(1'b0, 1'b1, 17'h00203, ONE_BYTE, 4'd4, 8'hFF, vd);
    wait_done("vl_done", 100);
    check("vl_count", log_n - base_n, 4);
    for (int i = 0; i < 4; i++) check("vl_addr", log_addr[base_n + i], ld_addr[i]);
    check("vl_vis", log_vis[base_n], D_CACHE_LOAD);
    exp_v = vd;
    for (int i = 0; i < 4; i++) exp_v[i*32 +: 32] = ld_data[i];
    check("vl_result", bus.result_vdata, exp_v);
    @(negedge clk);

    // TWO_BYTE vector store with address wrap
    stall_cycles = 0;
    base_n = log_n;
    send(1'b1, 1'b1, 17'h1FFFC, TWO_BYTE, 4'd8, 8'hFF, vd);
    wait_done("vs_done", 100);
    check("vs_count", log_n - base_n, 8);
    for (int i = 0; i < 8; i++) begin
      check("vs_addr", log_addr[base_n + i], st_addr[i]);
      check("vs_wdata", log_wdata[base_n + i], vd[i*32 +: 32]);
      check("vs_vis", log_vis[base_n + i], D_CACHE_STORE);
    end
    check("vs_result", bus.result_vdata, vd);
    @(negedge clk);

    // Cache busy: request must be held until the first RESTING cycle
    load_base = 32'h0;
    force_working = 1'b1;
    base_n = log_n;
    send(1'b0, 1'b0, 17'h00040, FOUR_BYTE, 4'd1, 8'h01, vd);
    for (int i = 0; i < 5; i++) begin
      check("hold_vis", bus.cache_vis_signal, D_CACHE_LOAD);
      check("hold_addr", bus.data_addr, 17'h00040);
      check("hold_noacc", log_n - base_n, 0);
      @(negedge clk);
    end
    force_working = 1'b0;
    wait_done("hold_done", 20);
    check("hold_count", log_n - base_n, 1);
    check("hold_lane0", bus.result_vdata[31:0], 32'h40);
    @(negedge clk);

    // vl=0: no access, done next cycle, err=0
    base_n = log_n;
    send(1'b0, 1'b1, 17'h00000, FOUR_BYTE, 4'd0, 8'hFF, vd);
    check("vl0_done", bus.done, 1'b1);
    check("vl0_err", bus.err, 1'b0);
    check("vl0_noacc", log_n - base_n, 0);
    @(negedge clk);
    check("vl0_pulse", bus.done, 1'b0);

    // EIGHT_BYTE: error, no access
    send(1'b0, 1'b1, 17'h00000, EIGHT_BYTE, 4'd4, 8'hFF, vd);
    check("e8_done", bus.done, 1'b1);
    check("e8_err", bus.err, 1'b1);
    check("e8_noacc", log_n - base_n, 0);
    @(negedge clk);

    // err cleared by the next request
    send(1'b0, 1'b1, 17'h00000, FOUR_BYTE, 4'd0, 8'hFF, vd);
    check("errclr", bus.err, 1'b0);
    @(negedge clk);

    // req_valid held through DONE is accepted in the following IDLE cycle
    bus.req_is_vector = 1'b1;
    bus.req_data_type = FOUR_BYTE;
    bus.req_vl        = 4'd0;
    bus.req_valid     = 1'b1;
    @(negedge clk);
    check("hv_done1", bus.done, 1'b1);
    @(negedge clk);
    check("hv_idle", bus.done, 1'b0);
    check("hv_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    check("hv_done2", bus.done, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("hv_end", bus.done, 1'b0);

    // Masked vector load (mask honoured only with VECTOR_MEM_CTRL_MASK_EN)
`ifdef VECTOR_MEM_CTRL_MASK_EN
    exp_mask = 8'hA5;
`else
    exp_mask = 8'hFF;
`endif
    load_base = 32'h0;
    stall_cycles = 0;
    base_n = log_n;
    send(1'b0, 1'b1, 17'h00100, FOUR_BYTE, 4'd8, 8'hA5, vd);
    wait_done("mk_done", 100);
    exp_v = vd;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (exp_mask[i]) begin
        exp_v[i*32 +: 32] = 32'h100 + 32'(4 * i);
        check("mk_addr", log_addr[base_n + k], 17'h100 + 17'(4 * i));
        k++;
      end
    end
    check("mk_count", log_n - base_n, k);
    check("mk_result", bus.result_vdata, exp_v);
    @(negedge clk);

    // Reset asserted mid-WAIT
    stall_cycles = 5;
    send(1'b0, 1'b1, 17'h00010, FOUR_BYTE, 4'd2, 8'hFF, vd);
    @(negedge clk);
    check("mw_vis_wait", bus.cache_vis_signal, D_CACHE_NOP);
    check("mw_busy", bus.req_ready, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mw_ready", bus.req_ready, 1'b1);
    check("mw_vis", bus.cache_vis_signal, D_CACHE_NOP);
    check("mw_done", bus.done, 1'b0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Recovery after reset
    stall_cycles = 0;
    send(1'b0, 1'b0, 17'h00020, FOUR_BYTE, 4'd1, 8'h01, vd);
    wait_done("rc_done", 20);
    check("rc_lane0", bus.result_vdata[31:0], 32'h20);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
